// File: rtl/usb_pkt_decoder.sv
// Receive-side USB packet decoder: serial LSB-first bits in, PID/body captured,
// CRC5/CRC16 residuals checked, decoded fields and error flags presented per packet.
//
// state | meaning
// IDLE  | waiting for sop; bits and eop ignored
// PIDS  | shifting in the 8 PID bits
// BODY  | shifting in body bits, running both CRC LFSRs
// CHECK | one cycle: pktDone high, results captured
module usb_pkt_decoder #(
  parameter int MAX_BYTES = 8
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic                           sop,
  input  logic                           bIn,
  input  logic                           bInValid,
  input  logic                           eop,
  output logic                           busy,
  output logic                           pktDone,
  output logic                           pktOk,
  output logic                           pidErr,
  output logic                           lenErr,
  output logic                           crcErr,
  output logic [3:0]                     pid,
  output logic [6:0]                     addr,
  output logic [3:0]                     endp,
  output logic [8*MAX_BYTES-1:0]         data,
  output logic [$clog2(MAX_BYTES+1)-1:0] dataLen
);

  localparam int DATA_W    = 8 * MAX_BYTES;
  localparam int BODY_MAX  = DATA_W + 16;
  localparam int CNT_W     = $clog2(BODY_MAX + 1);
  localparam int LEN_W     = $clog2(MAX_BYTES + 1);
  localparam int BIDX_W    = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BODY_MAX);
  localparam logic [CNT_W-1:0] CNT_16  = CNT_W'(16);
  localparam logic [CNT_W-1:0] CNT_7   = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_DW  = CNT_W'(DATA_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PIDS  = 2'd1;
  localparam logic [1:0] BODY  = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        pid_reg;
  logic [DATA_W-1:0] body;
  logic              overflow;
  logic              pid_short;
  logic [4:0]        crc5;
  logic [15:0]       crc16;

  logic              ok_q, pid_err_q, len_err_q, crc_err_q;
  logic [3:0]        pid_q, endp_q;
  logic [6:0]        addr_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  len_q;

  logic              res_pid_err, res_len_err, res_crc_err, crc_bad;
  logic [6:0]        res_addr;
  logic [3:0]        res_endp;
  logic [CNT_W-1:0]  payload_bits;
  logic [LEN_W-1:0]  res_len;
  logic [DATA_W-1:0] res_data;

  function automatic logic [4:0] crc5_next(input logic [4:0] c, input logic b);
    logic n0;
    n0 = c[4] ^ b;
    return {c[3], c[2], c[1] ^ n0, c[0], n0};
  endfunction

  function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic b);
    logic n0;
    n0 = c[15] ^ b;
    return {c[14] ^ n0, c[13:2], c[1] ^ n0, c[0], n0};
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      pid_reg   <= '0;
      body      <= '0;
      overflow  <= 1'b0;
      pid_short <= 1'b0;
      crc5      <= 5'h1F;
      crc16     <= 16'hFFFF;
      ok_q      <= 1'b0;
      pid_err_q <= 1'b0;
      len_err_q <= 1'b0;
      crc_err_q <= 1'b0;
      pid_q     <= '0;
      addr_q    <= '0;
      endp_q    <= '0;
      data_q    <= '0;
      len_q     <= '0;
    end else begin
      if (state == CHECK) begin
        ok_q      <= ~(res_pid_err | res_len_err | res_crc_err);
        pid_err_q <= res_pid_err;
        len_err_q <= res_len_err;
        crc_err_q <= res_crc_err;
        pid_q     <= pid_reg[3:0];
        addr_q    <= res_addr;
        endp_q    <= res_endp;
        data_q    <= res_data;
        len_q     <= res_len;
      end
      // sop wins in every state: aborts a packet in flight, or follows CHECK
      if (sop) begin
        state     <= PIDS;
        bit_cnt   <= '0;
        pid_reg   <= '0;
        body      <= '0;
        overflow  <= 1'b0;
        pid_short <= 1'b0;
        crc5      <= 5'h1F;
        crc16     <= 16'hFFFF;
      end else begin
        case (state)
          PIDS: begin
            if (bInValid) begin
              pid_reg[bit_cnt[2:0]] <= bIn;
              if (bit_cnt == CNT_7) begin
                bit_cnt <= '0;
                state   <= BODY;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (eop) begin
              state     <= CHECK;
              pid_short <= !(bInValid && bit_cnt == CNT_7);
            end
          end
          BODY: begin
            if (bInValid) begin
              if (bit_cnt < CNT_MAX) begin
                if (bit_cnt < CNT_DW) body[bit_cnt[BIDX_W-1:0]] <= bIn;
                crc5    <= crc5_next(crc5, bIn);
                crc16   <= crc16_next(crc16, bIn);
                bit_cnt <= bit_cnt + 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end
            if (eop) state <= CHECK;
          end
          CHECK:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    res_pid_err = (pid_reg[7:4] != ~pid_reg[3:0]) || (pid_reg[1:0] == 2'b00);
    res_len_err = 1'b0;
    crc_bad     = 1'b0;
    case (pid_reg[1:0])
      2'b01: begin
        res_len_err = (bit_cnt != CNT_16);
        crc_bad     = (crc5 != 5'b01100);
      end
      2'b11: begin
        res_len_err = overflow || (bit_cnt < CNT_16) || (bit_cnt[2:0] != 3'd0);
        crc_bad     = (crc16 != 16'h800D);
      end
      2'b10:   res_len_err = (bit_cnt != '0);
      default: ;
    endcase
    if (pid_short) res_len_err = 1'b1;
    res_crc_err = crc_bad & ~res_pid_err & ~res_len_err;

    res_addr = '0;
    res_endp = '0;
    if (pid_reg[1:0] == 2'b01) begin
      res_addr = body[6:0];
      res_endp = body[10:7];
    end

    payload_bits = bit_cnt - CNT_16;
    res_len      = '0;
    if (pid_reg[1:0] == 2'b11 && !res_len_err) res_len = LEN_W'(payload_bits >> 3);
    // CRC bytes sit just above the payload in body, so mask by length
    res_data = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (LEN_W'(i) < res_len) res_data[8*i +: 8] = body[8*i +: 8];
    end
  end

  assign busy    = (state != IDLE);
  assign pktDone = (state == CHECK);
  assign pktOk   = pktDone ? ~(res_pid_err | res_len_err | res_crc_err) : ok_q;
  assign pidErr  = pktDone ? res_pid_err  : pid_err_q;
  assign lenErr  = pktDone ? res_len_err  : len_err_q;
  assign crcErr  = pktDone ? res_crc_err  : crc_err_q;
  assign pid     = pktDone ? pid_reg[3:0] : pid_q;
  assign addr    = pktDone ? res_addr     : addr_q;
  assign endp    = pktDone ? res_endp     : endp_q;
  assign data    = pktDone ? res_data     : data_q;
  assign dataLen = pktDone ? res_len      : len_q;

endmodule
